// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel-rate prescaler, h/v scan counters, pixel request
// pulses and pipeline-aligned hsync/vsync/video_on for the pixel generator.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   req           one-clk pulse requesting the pixel at row/column
//   row, column   active pixel coordinates, held between active ticks
//   frame_start   one-clk pulse together with the req for pixel (0,0)
//   hsync, vsync  sync outputs, delayed PIPE_DELAY pixels, level SYNC_POL
//   video_on      active-area flag, delayed PIPE_DELAY pixels
module vga_timing_generator #(
  parameter int CLKS_PER_PIXEL = 4,
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter int PIPE_DELAY     = 2,
  parameter bit SYNC_POL       = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       req,
  output logic [8:0] row,
  output logic [9:0] column,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLKS_PER_PIXEL);

  localparam logic [DW-1:0] PD_LAST = DW'(CLKS_PER_PIXEL - 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Scan state
  logic [DW-1:0] pix_div_q, pix_div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;

  // Request side
  logic          req_q, req_d;
  logic          fs_q, fs_d;
  logic [8:0]    row_q, row_d;
  logic [9:0]    col_q, col_d;

  // Raw-value delay line, stage 0 holds the newest pixel
  logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_DELAY-1:0] von_pipe_q, von_pipe_d;

  // Output stage, raw (active-high) encoding
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          von_q, von_d;

  // Next-pixel decode
  logic          tick;
  logic          h_wrap;
  logic [9:0]    h_n;
  logic [9:0]    v_n;
  logic          active_n;
  logic          hs_raw;
  logic          vs_raw;

  always_comb begin
    tick   = (pix_div_q == PD_LAST);
    h_wrap = (h_q == H_LAST);
    h_n    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_n    = v_q;
    if (h_wrap) begin
      v_n = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end
    active_n = (h_n < H_ACT) && (v_n < V_ACT);
    hs_raw   = (h_n >= HS_BEG) && (h_n < HS_END);
    vs_raw   = (v_n >= VS_BEG) && (v_n < VS_END);
  end

  always_comb begin
    pix_div_d  = tick ? '0 : pix_div_q + 1'b1;
    h_d        = h_q;
    v_d        = v_q;
    req_d      = 1'b0;
    fs_d       = 1'b0;
    row_d      = row_q;
    col_d      = col_q;
    hs_pipe_d  = hs_pipe_q;
    vs_pipe_d  = vs_pipe_q;
    von_pipe_d = von_pipe_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    von_d      = von_q;
    if (tick) begin
      h_d   = h_n;
      v_d   = v_n;
      req_d = active_n;
      fs_d  = active_n && (h_n == 10'd0) && (v_n == 10'd0);
      if (active_n) begin
        row_d = v_n[8:0];
        col_d = h_n;
      end
      // Output takes the oldest stage before the shift, which gives
      // exactly PIPE_DELAY pixels between a raw value and its display.
      hs_d  = hs_pipe_q[PIPE_DELAY-1];
      vs_d  = vs_pipe_q[PIPE_DELAY-1];
      von_d = von_pipe_q[PIPE_DELAY-1];
      hs_pipe_d[0]  = hs_raw;
      vs_pipe_d[0]  = vs_raw;
      von_pipe_d[0] = active_n;
      for (int k = 1; k < PIPE_DELAY; k++) begin
        hs_pipe_d[k]  = hs_pipe_q[k-1];
        vs_pipe_d[k]  = vs_pipe_q[k-1];
        von_pipe_d[k] = von_pipe_q[k-1];
      end
    end
  end

  // Counters reset to their last values so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_div_q  <= PD_LAST;
      h_q        <= H_LAST;
      v_q        <= V_LAST;
      req_q      <= 1'b0;
      fs_q       <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      von_pipe_q <= '0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      von_q      <= 1'b0;
    end else begin
      pix_div_q  <= pix_div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      req_q      <= req_d;
      fs_q       <= fs_d;
      row_q      <= row_d;
      col_q      <= col_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
      von_pipe_q <= von_pipe_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      von_q      <= von_d;
    end
  end

  assign req         = req_q;
  assign frame_start = fs_q;
  assign row         = row_q;
  assign column      = col_q;
  assign video_on    = von_q;
  assign hsync       = ~(hs_q ^ SYNC_POL);
  assign vsync       = ~(vs_q ^ SYNC_POL);

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: full-size instance for line timing, reduced instance
// (positive sync, PIPE_DELAY 3) for frame, vsync and mid-frame reset.
module tb_vga_timing_generator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic       d_req, d_fs, d_hs, d_vs, d_von;
  logic [8:0] d_row;
  logic [9:0] d_col;

  logic       s_req, s_fs, s_hs, s_vs, s_von;
  logic [8:0] s_row;
  logic [9:0] s_col;

  vga_timing_generator dut (
    .clk(clk), .rst_n(rst_n), .req(d_req), .row(d_row), .column(d_col),
    .frame_start(d_fs), .hsync(d_hs), .vsync(d_vs), .video_on(d_von)
  );

  // 15 px/line (8 active, sync 10..12), 8 lines (4 active, vsync 5..6)
  // 60 clks per line, 480 clks per frame
  vga_timing_generator #(
    .CLKS_PER_PIXEL(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_DELAY(3), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .req(s_req), .row(s_row), .column(s_col),
    .frame_start(s_fs), .hsync(s_hs), .vsync(s_vs), .video_on(s_von)
  );

  // Leaves the bench at the negedge right after the first req edge (n=0).
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    checks++; if ({d_req, d_fs, d_von} !== 3'b000) begin failures++;
      $display("FAIL %s_d_pulses got=%b exp=000", tag, {d_req, d_fs, d_von}); end
    checks++; if ({d_row, d_col} !== 19'd0) begin failures++;
      $display("FAIL %s_d_rowcol got=%0d/%0d exp=0/0", tag, d_row, d_col); end
    checks++; if ({d_hs, d_vs} !== 2'b11) begin failures++;
      $display("FAIL %s_d_sync got=%b exp=11", tag, {d_hs, d_vs}); end
    checks++; if ({s_req, s_fs, s_von} !== 3'b000) begin failures++;
      $display("FAIL %s_s_pulses got=%b exp=000", tag, {s_req, s_fs, s_von}); end
    checks++; if ({s_row, s_col} !== 19'd0) begin failures++;
      $display("FAIL %s_s_rowcol got=%0d/%0d exp=0/0", tag, s_row, s_col); end
    checks++; if ({s_hs, s_vs} !== 2'b00) begin failures++;
      $display("FAIL %s_s_sync got=%b exp=00", tag, {s_hs, s_vs}); end
  endtask

  task automatic check_first_px(input string tag);
    checks++; if ({d_req, d_fs} !== 2'b11) begin failures++;
      $display("FAIL %s_d_req_fs got=%b exp=11", tag, {d_req, d_fs}); end
    checks++; if ({d_row, d_col} !== 19'd0) begin failures++;
      $display("FAIL %s_d_rowcol got=%0d/%0d exp=0/0", tag, d_row, d_col); end
    checks++; if ({s_req, s_fs} !== 2'b11) begin failures++;
      $display("FAIL %s_s_req_fs got=%b exp=11", tag, {s_req, s_fs}); end
    checks++; if ({s_row, s_col} !== 19'd0) begin failures++;
      $display("FAIL %s_s_rowcol got=%0d/%0d exp=0/0", tag, s_row, s_col); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_reset_vals("reset");
  endtask

  task automatic test_first_req();
    int gaps;
    do_reset();
    check_first_px("first");
    gaps = 0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      if (d_req !== 1'b0) gaps++;
    end
    checks++; if (gaps !== 0) begin failures++;
      $display("FAIL first_gap got=%0d exp=0", gaps); end
    @(negedge clk);
    checks++; if ({d_req, d_fs, d_col} !== {2'b10, 10'd1}) begin failures++;
      $display("FAIL second_req got=%b/%0d exp=10/1", {d_req, d_fs}, d_col); end
  endtask

  task automatic test_line();
    int reqs, colerr, blank, consec, nxt, col_exp;
    logic prev;
    logic [8:0] nrow;
    logic [9:0] ncol;
    reqs = 0; colerr = 0; blank = 0; consec = 0; nxt = -1; col_exp = 0;
    prev = 1'b0; nrow = '1; ncol = '1;
    do_reset();
    for (int n = 0; n < 3300; n++) begin
      if (d_req) begin
        if (prev) consec++;
        if (n < 3200) begin
          reqs++;
          if (n >= 2560) blank++;
          if (d_col != 10'(col_exp) || d_row != 9'd0) colerr++;
          col_exp++;
        end else if (nxt < 0) begin
          nxt = n; nrow = d_row; ncol = d_col;
        end
      end
      prev = d_req;
      @(negedge clk);
    end
    checks++; if (reqs !== 640) begin failures++;
      $display("FAIL line_reqs got=%0d exp=640", reqs); end
    checks++; if (colerr !== 0) begin failures++;
      $display("FAIL line_cols got=%0d bad exp=0", colerr); end
    checks++; if (blank !== 0) begin failures++;
      $display("FAIL line_blank_req got=%0d exp=0", blank); end
    checks++; if (consec !== 0) begin failures++;
      $display("FAIL line_consec got=%0d exp=0", consec); end
    checks++; if (nxt !== 3200) begin failures++;
      $display("FAIL line_next_at got=%0d exp=3200", nxt); end
    checks++; if ({nrow, ncol} !== {9'd1, 10'd0}) begin failures++;
      $display("FAIL line_next_pos got=%0d/%0d exp=1/0", nrow, ncol); end
  endtask

  task automatic test_hsync_video();
    int hfall, hlow, vr1, vr2, vhigh;
    logic ph, pv;
    hfall = -1; hlow = 0; vr1 = -1; vr2 = -1; vhigh = 0;
    ph = 1'b1; pv = 1'b0;
    do_reset();
    for (int n = 0; n < 3300; n++) begin
      if (!d_hs && ph && hfall < 0) hfall = n;
      if (!d_hs && n < 3200) hlow++;
      if (d_von && !pv) begin
        if (vr1 < 0) vr1 = n;
        else if (vr2 < 0) vr2 = n;
      end
      if (d_von && n < 3200) vhigh++;
      ph = d_hs; pv = d_von;
      @(negedge clk);
    end
    checks++; if (hfall !== 2632) begin failures++;
      $display("FAIL hsync_fall got=%0d exp=2632", hfall); end
    checks++; if (hlow !== 384) begin failures++;
      $display("FAIL hsync_low got=%0d exp=384", hlow); end
    checks++; if (vr1 !== 8) begin failures++;
      $display("FAIL von_rise got=%0d exp=8", vr1); end
    checks++; if (vhigh !== 2560) begin failures++;
      $display("FAIL von_high got=%0d exp=2560", vhigh); end
    checks++; if (vr2 !== 3208) begin failures++;
      $display("FAIL von_rise2 got=%0d exp=3208", vr2); end
  endtask

  task automatic test_frame_small();
    int reqs, maxrow, blank, fs1, fs2, fsn;
    reqs = 0; maxrow = 0; blank = 0; fs1 = -1; fs2 = -1; fsn = 0;
    do_reset();
    for (int n = 0; n < 962; n++) begin
      if (s_req) begin
        if (n < 480) reqs++;
        if (int'(s_row) > maxrow) maxrow = int'(s_row);
        if ((n % 480) / 60 >= 4) blank++;
      end
      if (s_fs) begin
        fsn++;
        if (fs1 < 0) fs1 = n;
        else if (fs2 < 0) fs2 = n;
      end
      @(negedge clk);
    end
    checks++; if (reqs !== 32) begin failures++;
      $display("FAIL frame_reqs got=%0d exp=32", reqs); end
    checks++; if (maxrow !== 3) begin failures++;
      $display("FAIL frame_maxrow got=%0d exp=3", maxrow); end
    checks++; if (blank !== 0) begin failures++;
      $display("FAIL frame_blank_req got=%0d exp=0", blank); end
    checks++; if (fs2 - fs1 !== 480) begin failures++;
      $display("FAIL frame_period got=%0d exp=480", fs2 - fs1); end
    checks++; if (fsn !== 3) begin failures++;
      $display("FAIL frame_fs_count got=%0d exp=3", fsn); end
  endtask

  task automatic test_sync_small();
    int hr, hf, vr, vhigh, vor, vof;
    logic ph, pv, po;
    hr = -1; hf = -1; vr = -1; vhigh = 0; vor = -1; vof = -1;
    ph = 1'b0; pv = 1'b0; po = 1'b0;
    do_reset();
    for (int n = 0; n < 480; n++) begin
      if (s_hs && !ph && hr < 0) hr = n;
      if (!s_hs && ph && hf < 0) hf = n;
      if (s_vs && !pv && vr < 0) vr = n;
      if (s_vs) vhigh++;
      if (s_von && !po && vor < 0) vor = n;
      if (!s_von && po && vof < 0) vof = n;
      ph = s_hs; pv = s_vs; po = s_von;
      @(negedge clk);
    end
    checks++; if (hr !== 52) begin failures++;
      $display("FAIL s_hsync_rise got=%0d exp=52", hr); end
    checks++; if (hf !== 64) begin failures++;
      $display("FAIL s_hsync_fall got=%0d exp=64", hf); end
    checks++; if (vr !== 312) begin failures++;
      $display("FAIL s_vsync_rise got=%0d exp=312", vr); end
    checks++; if (vhigh !== 120) begin failures++;
      $display("FAIL s_vsync_high got=%0d exp=120", vhigh); end
    checks++; if (vor !== 12) begin failures++;
      $display("FAIL s_von_rise got=%0d exp=12", vor); end
    checks++; if (vof !== 44) begin failures++;
      $display("FAIL s_von_fall got=%0d exp=44", vof); end
  endtask

  task automatic test_midframe_reset();
    bit found;
    found = 1'b0;
    do_reset();
    for (int n = 0; n < 1000 && !found; n++) begin
      if (s_req && s_row == 9'd2 && s_col == 10'd5) found = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!found) begin failures++;
      $display("FAIL mid_wait got=timeout exp=row2col5"); end
    checks++; if (s_von !== 1'b1) begin failures++;
      $display("FAIL mid_pre_von got=%b exp=1", s_von); end
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_first_px("mid_restart");
  endtask

  initial begin
    test_reset();
    test_first_req();
    test_line();
    test_hsync_video();
    test_frame_small();
    test_sync_small();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
